stats_unpacker_avlstrm: RTL and testbench

Receiving end of the statistics stream produced by the per-service stats packers. It takes stats records arriving as Avalon-ST snapshots, stages them, and commits each complete snapshot atomically into a shadow register file. A single-cycle-latency read port exposes the register file to the host CSR path. It sits in the same clock domain as the packer that feeds it; any CDC happens upstream of it.

---
 rtl/stats_pkg.sv | 20 ++
 rtl/avl_stream_if.sv | 13 +
 rtl/stats_shadow_regfile.sv | 83 ++++++++
 rtl/stats_unpacker_avlstrm.sv | 106 ++++++++++
 tb/tb_stats_unpacker_avlstrm.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/stats_pkg.sv
// Shared stats record definitions, used by both the packer and the unpacker side.
package stats_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] val;
  } stats_t;

  localparam logic [31:0] REG_RX_PKTS  = 32'd0;
  localparam logic [31:0] REG_TX_PKTS  = 32'd1;
  localparam logic [31:0] REG_RX_BYTES = 32'd2;
  localparam logic [31:0] REG_TX_BYTES = 32'd3;
  localparam logic [31:0] REG_DROPS    = 32'd4;

  function automatic logic addr_in_range(logic [31:0] addr, int unsigned base,
                                         int unsigned num);
    return (addr >= 32'(base)) && ((addr - 32'(base)) < 32'(num));
  endfunction

endpackage

// File: rtl/avl_stream_if.sv
// Minimal Avalon-ST bundle with start/end-of-packet framing.
interface avl_stream_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             valid;
  logic             ready;
  logic             sop;
  logic             eop;
  logic [WIDTH-1:0] data;

  modport tx (output valid, sop, eop, data, input ready);
  modport rx (input valid, sop, eop, data, output ready);
endinterface

// File: rtl/stats_shadow_regfile.sv
// Staging area with dirty tracking, atomic commit into live registers, registered read port.
module stats_shadow_regfile
  import stats_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned BASE_ADDR = 0,
  localparam int unsigned IdxW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            clear_i,
  input  logic            stage_we_i,
  input  logic [IdxW-1:0] stage_idx_i,
  input  logic [31:0]     stage_val_i,
  input  logic            commit_i,
  input  logic            rd_en_i,
  input  logic [31:0]     rd_addr_i,
  output logic            rd_valid_o,
  output logic [31:0]     rd_data_o
);

  logic [31:0]         stage_q [NUM_REGS];
  logic [31:0]         stage_d [NUM_REGS];
  logic [31:0]         live_q  [NUM_REGS];
  logic [31:0]         live_d  [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d, dirty_m;
  logic                rd_valid_q;
  logic [31:0]         rd_data_q, rd_data_d, rd_off;

  // Clear, then stage, then commit: the eop beat's own record is part of the commit.
  always_comb begin
    stage_d = stage_q;
    live_d  = live_q;
    dirty_m = dirty_q;
    if (clear_i) begin
      dirty_m = '0;
      for (int i = 0; i < NUM_REGS; i++) stage_d[i] = '0;
    end
    if (stage_we_i) begin
      stage_d[stage_idx_i] = stage_val_i;
      dirty_m[stage_idx_i] = 1'b1;
    end
    dirty_d = dirty_m;
    if (commit_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dirty_m[i]) live_d[i] = stage_d[i];
      end
      dirty_d = '0;
    end
  end

  // Reads use live_q, so a read coincident with a commit sees the old value.
  always_comb begin
    rd_off    = rd_addr_i - 32'(BASE_ADDR);
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = addr_in_range(rd_addr_i, BASE_ADDR, NUM_REGS) ?
                  live_q[rd_off[IdxW-1:0]] : 32'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        stage_q[i] <= '0;
        live_q[i]  <= '0;
      end
      dirty_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      stage_q    <= stage_d;
      live_q     <= live_d;
      dirty_q    <= dirty_d;
      rd_valid_q <= rd_en_i;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/stats_unpacker_avlstrm.sv
// Stats snapshot receiver: framing FSM, error/snapshot counters, shadow register file.
module stats_unpacker_avlstrm
  import stats_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic         Clk,
  input  logic         Rst,
  avl_stream_if.rx     in_stats,
  input  logic         rd_en,
  input  logic [31:0]  rd_addr,
  output logic         rd_valid,
  output logic [31:0]  rd_data,
  output logic [31:0]  snap_cnt,
  output logic [31:0]  err_cnt
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {StIdle, StCollect, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] snap_cnt_q, snap_cnt_d, err_cnt_q, err_cnt_d;
  logic [1:0]  err_inc;
  logic        beat, rec_ok, clear, stage_we, commit;
  logic [31:0] rec_off;
  stats_t      rec;

  assign in_stats.ready = ~Rst;
  assign beat    = in_stats.valid & in_stats.ready;
  assign rec     = stats_t'(in_stats.data);
  assign rec_ok  = addr_in_range(rec.addr, BASE_ADDR, NUM_REGS);
  assign rec_off = rec.addr - 32'(BASE_ADDR);

  always_comb begin
    state_d  = state_q;
    err_inc  = 2'd0;
    clear    = 1'b0;
    stage_we = 1'b0;
    commit   = 1'b0;
    if (beat) begin
      if (in_stats.sop) begin
        // A sop always starts a fresh snapshot; an open one is abandoned.
        clear    = 1'b1;
        stage_we = rec_ok;
        if (state_q == StCollect) err_inc = err_inc + 2'd1;
        if (!rec_ok) err_inc = err_inc + 2'd1;
        commit  = in_stats.eop;
        state_d = in_stats.eop ? StIdle : StCollect;
      end else begin
        unique case (state_q)
          StCollect: begin
            stage_we = rec_ok;
            if (!rec_ok) err_inc = 2'd1;
            commit   = in_stats.eop;
            if (in_stats.eop) state_d = StIdle;
          end
          StIdle: begin
            err_inc = 2'd1;
            state_d = in_stats.eop ? StIdle : StDrop;
          end
          StDrop: begin
            if (in_stats.eop) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
    snap_cnt_d = snap_cnt_q + 32'(commit);
    err_cnt_d  = err_cnt_q + 32'(err_inc);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      snap_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      snap_cnt_q <= snap_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign snap_cnt = snap_cnt_q;
  assign err_cnt  = err_cnt_q;

  stats_shadow_regfile #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_regfile (
    .Clk         (Clk),
    .Rst         (Rst),
    .clear_i     (clear),
    .stage_we_i  (stage_we),
    .stage_idx_i (rec_off[IdxW-1:0]),
    .stage_val_i (rec.val),
    .commit_i    (commit),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data)
  );

endmodule

// File: tb/tb_stats_unpacker_avlstrm.sv
// Directed and random snapshot traffic checked against a queue-based snapshot model.
module tb_stats_unpacker_avlstrm;
  localparam int unsigned NumRegs  = 32;
  localparam int unsigned BaseAddr = 0;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_valid;
  logic [31:0] rd_data, snap_cnt, err_cnt;

  avl_stream_if #(.WIDTH(64)) s_if ();

  stats_unpacker_avlstrm #(
    .NUM_REGS  (NumRegs),
    .BASE_ADDR (BaseAddr)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .in_stats (s_if.rx),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .snap_cnt (snap_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Reference model: a snapshot is a list of pending writes applied in order at eop.
  typedef struct {
    int          idx;
    logic [31:0] val;
  } wr_t;

  logic [31:0] m_live [NumRegs];
  wr_t         m_pend [$];
  bit          m_open, m_dropping;
  logic [31:0] m_snap, m_err, m_last_rd;

  task automatic model_reset();
    for (int i = 0; i < NumRegs; i++) m_live[i] = '0;
    m_pend.delete();
    m_open = 0; m_dropping = 0;
    m_snap = 0; m_err = 0; m_last_rd = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a >= BaseAddr && a - BaseAddr < NumRegs) return m_live[a - BaseAddr];
    return 32'd0;
  endfunction

  task automatic model_beat(input bit sop, input bit eop, input logic [31:0] a,
                            input logic [31:0] v);
    if (sop) begin
      if (m_open) begin
        m_err++;
        m_pend.delete();
      end
      m_open = 1; m_dropping = 0;
    end else if (!m_open) begin
      if (!m_dropping) begin
        m_err++;
        m_dropping = !eop;
      end else if (eop) begin
        m_dropping = 0;
      end
      return;
    end
    if (a >= BaseAddr && a - BaseAddr < NumRegs) m_pend.push_back('{int'(a - BaseAddr), v});
    else m_err++;
    if (eop) begin
      foreach (m_pend[k]) m_live[m_pend[k].idx] = m_pend[k].val;
      m_pend.delete();
      m_snap++;
      m_open = 0;
    end
  endtask

  // One clock cycle with an optional beat and optional read; checks everything visible after it.
  task automatic cycle(input bit v, input bit sop, input bit eop, input logic [31:0] a,
                       input logic [31:0] val, input bit re, input logic [31:0] ra);
    logic [31:0] exp_rd;
    s_if.valid = v; s_if.sop = sop; s_if.eop = eop; s_if.data = {a, val};
    rd_en = re; rd_addr = ra;
    @(posedge Clk);
    exp_rd = re ? model_read(ra) : m_last_rd;
    m_last_rd = exp_rd;
    if (v) model_beat(sop, eop, a, val);
    #1;
    check("rd_valid", 32'(rd_valid), 32'(re));
    check($sformatf("rd_data[%0d]", ra), rd_data, exp_rd);
    check("snap_cnt", snap_cnt, m_snap);
    check("err_cnt", err_cnt, m_err);
    s_if.valid = 0; rd_en = 0;
  endtask

  task automatic beat(input bit sop, input bit eop, input logic [31:0] a, input logic [31:0] v);
    cycle(1, sop, eop, a, v, 0, 0);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(0, 0, 0, 0, 0, 1, a);
  endtask

  task automatic do_reset();
    Rst = 1; s_if.valid = 0; rd_en = 0;
    repeat (2) begin
      @(posedge Clk); #1;
      check("ready_in_reset", 32'(s_if.ready), 32'd0);
    end
    Rst = 0;
    model_reset();
    #1;
    check("ready_after_reset", 32'(s_if.ready), 32'd1);
    check("rd_valid_reset", 32'(rd_valid), 32'd0);
    check("rd_data_reset", rd_data, 32'd0);
  endtask

  initial begin
    s_if.valid = 0; s_if.sop = 0; s_if.eop = 0; s_if.data = '0;
    model_reset();
    do_reset();
    check("snap_cnt_reset", snap_cnt, 32'd0);
    check("err_cnt_reset", err_cnt, 32'd0);

    // Three-record snapshot, then partial update
    beat(1, 0, 2, 32'h11); beat(0, 0, 5, 32'h22); beat(0, 1, 7, 32'h33);
    rd(2); check("t1_a2", rd_data, 32'h11);
    rd(5); check("t1_a5", rd_data, 32'h22);
    rd(7); check("t1_a7", rd_data, 32'h33);
    rd(3); check("t1_a3", rd_data, 32'h0);
    check("t1_snap", snap_cnt, 32'd1);
    beat(1, 1, 5, 32'h99);
    rd(2); check("t2_a2", rd_data, 32'h11);
    rd(5); check("t2_a5", rd_data, 32'h99);
    check("t2_snap", snap_cnt, 32'd2);
    // Read coincident with commit returns the old value
    cycle(1, 1, 1, 5, 32'hAA, 1, 5); check("t3_same", rd_data, 32'h99);
    rd(5); check("t3_next", rd_data, 32'hAA);
    cycle(0, 0, 0, 0, 0, 0, 0); check("t3_hold", rd_data, 32'hAA);

    do_reset();
    beat(1, 0, 4, 32'd1); beat(1, 1, 4, 32'd2);
    rd(4); check("t4_a4", rd_data, 32'd2);
    check("t4_err", err_cnt, 32'd1);
    check("t4_snap", snap_cnt, 32'd1);

    do_reset();
    beat(0, 0, 1, 32'd7); beat(0, 1, 0, 32'd0);
    rd(1); check("t5_a1", rd_data, 32'd0);
    check("t5_err", err_cnt, 32'd1);
    check("t5_snap", snap_cnt, 32'd0);

    do_reset();
    beat(1, 0, 3, 32'd5); beat(0, 0, NumRegs + BaseAddr, 32'd1); beat(0, 1, 6, 32'd9);
    rd(3); check("t6_a3", rd_data, 32'd5);
    rd(6); check("t6_a6", rd_data, 32'd9);
    check("t6_err", err_cnt, 32'd1);
    check("t6_snap", snap_cnt, 32'd1);
    // Abandoned snapshot plus out-of-range new record counts twice
    beat(1, 0, 3, 32'd1); beat(1, 1, 40, 32'd2);
    check("t6_double_err", err_cnt, 32'd3);

    beat(1, 0, 8, 32'h55);
    do_reset();
    beat(0, 1, 9, 32'h1);
    rd(8); check("t7_a8", rd_data, 32'd0);
    check("t7_snap", snap_cnt, 32'd0);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, NumRegs + 3), $urandom, $urandom_range(0, 1),
            $urandom_range(0, NumRegs + 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
